// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the instruction-memory boot loader: host command encoding
// and loader FSM states.
package imem_boot_loader_pkg;

  localparam int BOOT_CMD_W = 2;

  typedef enum logic [BOOT_CMD_W-1:0] {
    CMD_WRITE     = 2'b00,
    CMD_WRITE_INC = 2'b01,
    CMD_START     = 2'b10,
    CMD_HALT      = 2'b11
  } boot_cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host command handshake plus the per-core memory/run control bus of the loader.
interface imem_boot_loader_if #(
  parameter int CORES      = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_AW    = 9
) ();
  import imem_boot_loader_pkg::*;

  logic                  host_valid;
  logic                  host_ready;
  logic [BOOT_CMD_W-1:0] host_cmd;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_data;
  logic [CORES-1:0]      host_core;
  logic [CORES-1:0]      imem_we;
  logic [IMEM_AW-1:0]    imem_waddr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic [CORES-1:0]      core_run;
  logic [CORES-1:0]      core_pc_rst;
  logic [DATA_WIDTH-1:0] checksum;
  logic                  err;

  modport master (
    output host_valid, host_cmd, host_addr, host_data, host_core,
    input  host_ready, imem_we, imem_waddr, imem_wdata, core_run,
           core_pc_rst, checksum, err
  );

  modport slave (
    input  host_valid, host_cmd, host_addr, host_data, host_core,
    output host_ready, imem_we, imem_waddr, imem_wdata, core_run,
           core_pc_rst, checksum, err
  );

endinterface

// File: rtl/imem_boot_loader_addr_check.sv
// Combinational legality check shared by WRITE and WRITE_INC: alignment, range,
// one-hot target and target-halted, plus the resolved word address.
module boot_addr_check #(
  parameter int CORES      = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int IMEM_AW    = 9
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [IMEM_AW-1:0]    ptr_i,
  input  logic                  usePtr_i,
  input  logic [CORES-1:0]      core_i,
  input  logic [CORES-1:0]      coreRun_i,
  output logic                  ok_o,
  output logic [IMEM_AW-1:0]    wordAddr_o
);

  logic alignOk;
  logic rangeOk;
  logic coreOk;

  // The burst pointer is always aligned and in range, so only the core checks apply to it.
  assign alignOk    = usePtr_i || (addr_i[1:0] == 2'b00);
  assign rangeOk    = usePtr_i || ((addr_i >> (IMEM_AW + 2)) == '0);
  assign coreOk     = $onehot(core_i) && ((core_i & coreRun_i) == '0);
  assign ok_o       = alignOk && rangeOk && coreOk;
  assign wordAddr_o = usePtr_i ? ptr_i : addr_i[IMEM_AW+1:2];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader between a host command port and CORES instruction memories:
// addressed/burst writes, per-core start (with pc reset pulse) and halt.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int CORES      = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_AW    = 9
) (
  input logic               clk,
  input logic               rst,
  imem_boot_loader_if.slave bus_io
);

  boot_state_e           state_q, state_d;
  logic                  ready_q, ready_d;
  logic [IMEM_AW:0]      ptr_q, ptr_d;
  logic [CORES-1:0]      imemWe_q, imemWe_d;
  logic [IMEM_AW-1:0]    waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CORES-1:0]      coreRun_q, coreRun_d;
  logic [CORES-1:0]      pcRst_q, pcRst_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic                  err_q, err_d;

  boot_cmd_e          cmd;
  logic               accept;
  logic               writeOk;
  logic [IMEM_AW-1:0] wordAddr;

  assign cmd    = boot_cmd_e'(bus_io.host_cmd);
  assign accept = bus_io.host_valid && ready_q;

  boot_addr_check #(
    .CORES      (CORES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IMEM_AW    (IMEM_AW)
  ) u_addr_check (
    .addr_i     (bus_io.host_addr),
    .ptr_i      (ptr_q[IMEM_AW-1:0]),
    .usePtr_i   (cmd == CMD_WRITE_INC),
    .core_i     (bus_io.host_core),
    .coreRun_i  (coreRun_q),
    .ok_o       (writeOk),
    .wordAddr_o (wordAddr)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    imemWe_d   = '0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    coreRun_d  = coreRun_q;
    pcRst_d    = '0;
    checksum_d = checksum_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && (bus_io.host_core != '0)) begin
          case (cmd)
            CMD_WRITE, CMD_WRITE_INC: begin
              if (writeOk) begin
                imemWe_d   = bus_io.host_core;
                waddr_d    = wordAddr;
                wdata_d    = bus_io.host_data;
                checksum_d = checksum_q + bus_io.host_data;
                if (cmd == CMD_WRITE) begin
                  // The extra pointer bit remembers a WRITE to the last word, so the
                  // following burst write reports the wrap just like an in-burst wrap.
                  ptr_d = {1'b0, wordAddr} + {{IMEM_AW{1'b0}}, 1'b1};
                end else begin
                  ptr_d = {1'b0, wordAddr + {{(IMEM_AW-1){1'b0}}, 1'b1}};
                  if (ptr_q[IMEM_AW] || (&ptr_q[IMEM_AW-1:0])) err_d = 1'b1;
                end
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_START: begin
              pcRst_d = bus_io.host_core;
              state_d = ST_PULSE;
            end
            CMD_HALT: begin
              coreRun_d = coreRun_q & ~bus_io.host_core;
              if (&bus_io.host_core) begin
                checksum_d = '0;
                err_d      = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_PULSE: begin
        coreRun_d = coreRun_q | pcRst_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      ptr_q      <= '0;
      imemWe_q   <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      coreRun_q  <= '0;
      pcRst_q    <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      ptr_q      <= ptr_d;
      imemWe_q   <= imemWe_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      coreRun_q  <= coreRun_d;
      pcRst_q    <= pcRst_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
    end
  end

  assign bus_io.host_ready  = ready_q;
  assign bus_io.imem_we     = imemWe_q;
  assign bus_io.imem_waddr  = waddr_q;
  assign bus_io.imem_wdata  = wdata_q;
  assign bus_io.core_run    = coreRun_q;
  assign bus_io.core_pc_rst = pcRst_q;
  assign bus_io.checksum    = checksum_q;
  assign bus_io.err         = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with two cores; inputs change and outputs
// are sampled on the falling clock edge.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int CORES      = 2;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int IMEM_AW    = 9;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  imem_boot_loader_if #(
    .CORES(CORES), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .IMEM_AW(IMEM_AW)
  ) bus ();

  imem_boot_loader #(
    .CORES(CORES), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .IMEM_AW(IMEM_AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Present one command for a single clock, then sample after the accepting edge.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [1:0] core);
    bus.host_valid = 1'b1;
    bus.host_cmd   = cmd;
    bus.host_addr  = addr;
    bus.host_data  = data;
    bus.host_core  = core;
    @(negedge clk);
  endtask

  task automatic idleBus();
    bus.host_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.host_valid = 1'b0;
    bus.host_cmd = 2'b00; bus.host_addr = '0; bus.host_data = '0; bus.host_core = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready actual=%b required=0", bus.host_ready); end
    checks++; if (bus.imem_we !== 2'b00) begin errors++; $display("[TB] FAIL reset_we actual=%b required=00", bus.imem_we); end
    checks++; if (bus.core_run !== 2'b00) begin errors++; $display("[TB] FAIL reset_run actual=%b required=00", bus.core_run); end
    checks++; if (bus.core_pc_rst !== 2'b00) begin errors++; $display("[TB] FAIL reset_pcrst actual=%b required=00", bus.core_pc_rst); end
    checks++; if (bus.checksum !== 32'h0) begin errors++; $display("[TB] FAIL reset_checksum actual=%h required=0", bus.checksum); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err actual=%b required=0", bus.err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset actual=%b required=1", bus.host_ready); end
  endtask

  task automatic test_write();
    applyStimulus(CMD_WRITE, 32'h10, 32'hDEADBEEF, 2'b01);
    checks++; if (bus.imem_we !== 2'b01) begin errors++; $display("[TB] FAIL write_we actual=%b required=01", bus.imem_we); end
    checks++; if (bus.imem_waddr !== 9'd4) begin errors++; $display("[TB] FAIL write_waddr actual=%0d required=4", bus.imem_waddr); end
    checks++; if (bus.imem_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_wdata actual=%h required=deadbeef", bus.imem_wdata); end
    checks++; if (bus.checksum !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_checksum actual=%h required=deadbeef", bus.checksum); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL write_err actual=%b required=0", bus.err); end
    idleBus();
    checks++; if (bus.imem_we !== 2'b00) begin errors++; $display("[TB] FAIL write_we_one_cycle actual=%b required=00", bus.imem_we); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] burstData [4] = '{32'hA, 32'h1, 32'h2, 32'h3};
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i == 0) ? CMD_WRITE : CMD_WRITE_INC, 32'h0, burstData[i], 2'b10);
      checks++; if (bus.imem_we !== 2'b10) begin errors++; $display("[TB] FAIL burst_we[%0d] actual=%b required=10", i, bus.imem_we); end
      checks++; if (bus.imem_waddr !== 9'(i)) begin errors++; $display("[TB] FAIL burst_waddr[%0d] actual=%0d required=%0d", i, bus.imem_waddr, i); end
      checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("[TB] FAIL burst_ready[%0d] actual=%b required=1", i, bus.host_ready); end
    end
    checks++; if (bus.checksum !== 32'hDEADBEFF) begin errors++; $display("[TB] FAIL burst_checksum actual=%h required=deadbeff", bus.checksum); end
    idleBus();
  endtask

  task automatic test_start();
    applyStimulus(CMD_START, 32'h0, 32'h0, 2'b01);
    checks++; if (bus.core_pc_rst !== 2'b01) begin errors++; $display("[TB] FAIL start_pcrst actual=%b required=01", bus.core_pc_rst); end
    checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("[TB] FAIL start_pulse_ready actual=%b required=0", bus.host_ready); end
    checks++; if (bus.core_run !== 2'b00) begin errors++; $display("[TB] FAIL start_run_early actual=%b required=00", bus.core_run); end
    idleBus();
    checks++; if (bus.core_run !== 2'b01) begin errors++; $display("[TB] FAIL start_run actual=%b required=01", bus.core_run); end
    checks++; if (bus.core_pc_rst !== 2'b00) begin errors++; $display("[TB] FAIL start_pcrst_end actual=%b required=00", bus.core_pc_rst); end
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("[TB] FAIL start_ready_back actual=%b required=1", bus.host_ready); end
    applyStimulus(CMD_WRITE, 32'h20, 32'h55, 2'b01);
    checks++; if (bus.imem_we !== 2'b00) begin errors++; $display("[TB] FAIL running_write_we actual=%b required=00", bus.imem_we); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL running_write_err actual=%b required=1", bus.err); end
    checks++; if (bus.checksum !== 32'hDEADBEFF) begin errors++; $display("[TB] FAIL running_write_checksum actual=%h required=deadbeff", bus.checksum); end
    idleBus();
  endtask

  task automatic test_illegal_and_halt();
    applyStimulus(CMD_HALT, 32'h0, 32'h0, 2'b11);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL fullhalt_err actual=%b required=0", bus.err); end
    checks++; if (bus.checksum !== 32'h0) begin errors++; $display("[TB] FAIL fullhalt_checksum actual=%h required=0", bus.checksum); end
    checks++; if (bus.core_run !== 2'b00) begin errors++; $display("[TB] FAIL fullhalt_run actual=%b required=00", bus.core_run); end
    applyStimulus(CMD_WRITE, 32'h0, 32'h9, 2'b00);
    checks++; if (bus.err !== 1'b0 || bus.imem_we !== 2'b00) begin errors++; $display("[TB] FAIL zeromask_write err=%b we=%b required err=0 we=00", bus.err, bus.imem_we); end
    applyStimulus(CMD_START, 32'h0, 32'h0, 2'b00);
    checks++; if (bus.host_ready !== 1'b1 || bus.core_pc_rst !== 2'b00) begin errors++; $display("[TB] FAIL zeromask_start ready=%b pcrst=%b required ready=1 pcrst=00", bus.host_ready, bus.core_pc_rst); end
    applyStimulus(CMD_WRITE, 32'h802, 32'h1, 2'b01);
    checks++; if (bus.imem_we !== 2'b00 || bus.err !== 1'b1) begin errors++; $display("[TB] FAIL misaligned we=%b err=%b required we=00 err=1", bus.imem_we, bus.err); end
    applyStimulus(CMD_WRITE, 32'h800, 32'h1, 2'b01);
    checks++; if (bus.imem_we !== 2'b00 || bus.checksum !== 32'h0) begin errors++; $display("[TB] FAIL out_of_range we=%b checksum=%h required we=00 checksum=0", bus.imem_we, bus.checksum); end
    applyStimulus(CMD_WRITE, 32'h4, 32'h1, 2'b11);
    checks++; if (bus.imem_we !== 2'b00 || bus.err !== 1'b1) begin errors++; $display("[TB] FAIL multicore_write we=%b err=%b required we=00 err=1", bus.imem_we, bus.err); end
    applyStimulus(CMD_START, 32'h0, 32'h0, 2'b11);
    idleBus();
    checks++; if (bus.core_run !== 2'b11) begin errors++; $display("[TB] FAIL start_both_run actual=%b required=11", bus.core_run); end
    applyStimulus(CMD_HALT, 32'h0, 32'h0, 2'b01);
    checks++; if (bus.core_run !== 2'b10 || bus.err !== 1'b1) begin errors++; $display("[TB] FAIL partial_halt run=%b err=%b required run=10 err=1", bus.core_run, bus.err); end
    applyStimulus(CMD_HALT, 32'h0, 32'h0, 2'b11);
    checks++; if (bus.core_run !== 2'b00 || bus.err !== 1'b0) begin errors++; $display("[TB] FAIL fullhalt2 run=%b err=%b required run=00 err=0", bus.core_run, bus.err); end
    idleBus();
  endtask

  task automatic test_wrap();
    applyStimulus(CMD_WRITE, 32'h7FC, 32'hFFFFFFFF, 2'b01);
    checks++; if (bus.imem_waddr !== 9'd511 || bus.err !== 1'b0) begin errors++; $display("[TB] FAIL last_word waddr=%0d err=%b required waddr=511 err=0", bus.imem_waddr, bus.err); end
    applyStimulus(CMD_WRITE_INC, 32'h0, 32'h2, 2'b01);
    checks++; if (bus.imem_we !== 2'b01 || bus.imem_waddr !== 9'd0) begin errors++; $display("[TB] FAIL wrap_write we=%b waddr=%0d required we=01 waddr=0", bus.imem_we, bus.imem_waddr); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL wrap_err actual=%b required=1", bus.err); end
    checks++; if (bus.checksum !== 32'h1) begin errors++; $display("[TB] FAIL checksum_wrap actual=%h required=1", bus.checksum); end
    applyStimulus(CMD_HALT, 32'h0, 32'h0, 2'b11);
    applyStimulus(CMD_WRITE, 32'h7F8, 32'h0, 2'b10);
    applyStimulus(CMD_WRITE_INC, 32'h0, 32'h0, 2'b10);
    checks++; if (bus.imem_waddr !== 9'd511 || bus.imem_we !== 2'b10) begin errors++; $display("[TB] FAIL inc_last waddr=%0d we=%b required waddr=511 we=10", bus.imem_waddr, bus.imem_we); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL inc_last_err actual=%b required=1", bus.err); end
    applyStimulus(CMD_WRITE_INC, 32'h0, 32'h0, 2'b10);
    checks++; if (bus.imem_waddr !== 9'd0) begin errors++; $display("[TB] FAIL inc_after_wrap waddr=%0d required=0", bus.imem_waddr); end
    applyStimulus(CMD_HALT, 32'h0, 32'h0, 2'b11);
    idleBus();
  endtask

  task automatic test_reset_mid();
    applyStimulus(CMD_WRITE, 32'h40, 32'h7, 2'b10);
    applyStimulus(CMD_WRITE_INC, 32'h0, 32'h8, 2'b10);
    #2 rst = 1'b1;
    bus.host_valid = 1'b0;
    #1;
    checks++; if (bus.imem_we !== 2'b00 || bus.checksum !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_burst we=%b checksum=%h required we=00 checksum=0", bus.imem_we, bus.checksum); end
    checks++; if (bus.host_ready !== 1'b0 || bus.imem_waddr !== 9'd0) begin errors++; $display("[TB] FAIL async_reset_ready ready=%b waddr=%0d required ready=0 waddr=0", bus.host_ready, bus.imem_waddr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(CMD_WRITE_INC, 32'h0, 32'h5, 2'b10);
    checks++; if (bus.imem_waddr !== 9'd0 || bus.imem_we !== 2'b10 || bus.checksum !== 32'h5) begin errors++; $display("[TB] FAIL post_reset_inc waddr=%0d we=%b checksum=%h required waddr=0 we=10 checksum=5", bus.imem_waddr, bus.imem_we, bus.checksum); end
    applyStimulus(CMD_START, 32'h0, 32'h0, 2'b11);
    #2 rst = 1'b1;
    bus.host_valid = 1'b0;
    #1;
    checks++; if (bus.core_pc_rst !== 2'b00 || bus.host_ready !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_pulse pcrst=%b ready=%b required pcrst=00 ready=0", bus.core_pc_rst, bus.host_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.core_run !== 2'b00 || bus.host_ready !== 1'b1) begin errors++; $display("[TB] FAIL after_pulse_reset run=%b ready=%b required run=00 ready=1", bus.core_run, bus.host_ready); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_start();
    test_illegal_and_halt();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
